// File: rtl/dac_slew_ctrl.sv
// Slew-limited DAC code sequencer: steps the issued code toward a target on each update tick
// and hands one 24-bit word per update to a downstream SPI DAC driver, waiting out its busy flag.
module dac_slew_ctrl #(
    parameter logic [15:0] INIT_VALUE = 16'h8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_set_valid,
    input  logic [15:0] i_set_value,
    input  logic [15:0] i_step,
    input  logic [1:0]  i_pd_mode,
    input  logic        i_tick,
    input  logic        i_dac_busy,
    input  logic        i_clr_miss,
    output logic        o_wr,
    output logic [23:0] o_wr_data,
    output logic [15:0] o_cur_value,
    output logic        o_settled,
    output logic        o_tick_miss
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] tgt;
    logic [15:0] cur;
    logic [15:0] next_code;
    logic [16:0] diff;
    logic [1:0]  pd_last;
    logic        force_upd;
    logic        wait_first;
    logic        need_upd;
    logic        start;

    // Distance is computed without wrap, so a step can never overshoot past 0 or 65535.
    always_comb begin
        diff = (tgt > cur) ? ({1'b0, tgt} - {1'b0, cur}) : ({1'b0, cur} - {1'b0, tgt});
        if (i_step == 16'd0 || diff <= {1'b0, i_step})
            next_code = tgt;
        else if (tgt > cur)
            next_code = cur + i_step;
        else
            next_code = cur - i_step;
    end

    assign need_upd = (cur != tgt) || (i_pd_mode != pd_last) || force_upd;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        o_wr      = 1'b0;
        case (state)
            IDLE: begin
                if (i_tick && need_upd) begin
                    start     = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                o_wr      = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                // The driver's busy flag lags by a cycle, so the first WAIT cycle cannot trust it.
                if (!wait_first && !i_dac_busy)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tgt         <= INIT_VALUE;
            cur         <= INIT_VALUE;
            pd_last     <= 2'b00;
            force_upd   <= 1'b1;
            o_wr_data   <= 24'd0;
            o_tick_miss <= 1'b0;
            wait_first  <= 1'b0;
        end else begin
            if (i_set_valid)
                tgt <= i_set_value;
            if (start) begin
                cur       <= next_code;
                pd_last   <= i_pd_mode;
                force_upd <= 1'b0;
                o_wr_data <= {6'b0, i_pd_mode, next_code};
            end
            wait_first <= (state == WRITE);
            if (i_tick && state != IDLE)
                o_tick_miss <= 1'b1;
            else if (i_clr_miss)
                o_tick_miss <= 1'b0;
        end
    end

    assign o_cur_value = cur;
    assign o_settled   = (state == IDLE) && (cur == tgt) && !force_upd && (i_pd_mode == pd_last);

endmodule

// File: tb/tb_dac_slew_ctrl.sv
// Directed bench for dac_slew_ctrl: vector table of tick updates plus hand sequences for
// same-edge set/tick, busy hold with tick-miss, and reset in the middle of WAIT.
module tb_dac_slew_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_set_valid;
    logic [15:0] i_set_value;
    logic [15:0] i_step;
    logic [1:0]  i_pd_mode;
    logic        i_tick;
    logic        i_dac_busy;
    logic        i_clr_miss;
    logic        o_wr;
    logic [23:0] o_wr_data;
    logic [15:0] o_cur_value;
    logic        o_settled;
    logic        o_tick_miss;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dac_slew_ctrl #(.INIT_VALUE(16'h8000)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_set_valid(i_set_valid),
        .i_set_value(i_set_value),
        .i_step     (i_step),
        .i_pd_mode  (i_pd_mode),
        .i_tick     (i_tick),
        .i_dac_busy (i_dac_busy),
        .i_clr_miss (i_clr_miss),
        .o_wr       (o_wr),
        .o_wr_data  (o_wr_data),
        .o_cur_value(o_cur_value),
        .o_settled  (o_settled),
        .o_tick_miss(o_tick_miss)
    );

    typedef struct {
        logic        do_set;
        logic [15:0] set_val;
        logic [15:0] step;
        logic [1:0]  pd;
        int          exp_cnt;
        logic [23:0] exp_data;
        logic [15:0] exp_cur;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One tick, then watch six cycles: counts o_wr pulses and captures the last written word.
    task automatic tick_and_watch(output int cnt, output logic [23:0] data);
        cnt  = 0;
        data = 24'hxxxxxx;
        @(posedge clk); #1;
        i_tick = 1'b1;
        @(posedge clk); #1;
        i_tick = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (o_wr === 1'b1) begin
                cnt++;
                data = o_wr_data;
            end
        end
    endtask

    task automatic set_target(input logic [15:0] v);
        @(posedge clk); #1;
        i_set_valid = 1'b1;
        i_set_value = v;
        @(posedge clk); #1;
        i_set_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int          cnt;
        logic [23:0] data;

        vecs[0]  = '{1'b0, 16'h0000, 16'h0000, 2'b00, 1, 24'h008000, 16'h8000};
        vecs[1]  = '{1'b0, 16'h0000, 16'h0000, 2'b00, 0, 24'h000000, 16'h8000};
        vecs[2]  = '{1'b1, 16'h8100, 16'h0040, 2'b00, 1, 24'h008040, 16'h8040};
        vecs[3]  = '{1'b0, 16'h0000, 16'h0040, 2'b00, 1, 24'h008080, 16'h8080};
        vecs[4]  = '{1'b0, 16'h0000, 16'h0040, 2'b00, 1, 24'h0080C0, 16'h80C0};
        vecs[5]  = '{1'b0, 16'h0000, 16'h0040, 2'b00, 1, 24'h008100, 16'h8100};
        vecs[6]  = '{1'b0, 16'h0000, 16'h0040, 2'b00, 0, 24'h000000, 16'h8100};
        vecs[7]  = '{1'b1, 16'h0010, 16'h0000, 2'b00, 1, 24'h000010, 16'h0010};
        vecs[8]  = '{1'b1, 16'h0000, 16'h0020, 2'b00, 1, 24'h000000, 16'h0000};
        vecs[9]  = '{1'b1, 16'hFFFF, 16'h0000, 2'b00, 1, 24'h00FFFF, 16'hFFFF};
        vecs[10] = '{1'b0, 16'h0000, 16'h0000, 2'b01, 1, 24'h01FFFF, 16'hFFFF};
        vecs[11] = '{1'b0, 16'h0000, 16'h0000, 2'b01, 0, 24'h000000, 16'hFFFF};
        vecs[12] = '{1'b0, 16'h0000, 16'h0000, 2'b00, 1, 24'h00FFFF, 16'hFFFF};

        rst = 1'b1; i_set_valid = 1'b0; i_set_value = 16'h0; i_step = 16'h0;
        i_pd_mode = 2'b00; i_tick = 1'b0; i_dac_busy = 1'b0; i_clr_miss = 1'b0;
        do_reset();
        @(negedge clk);
        check("reset_wr", {31'b0, o_wr}, 32'd0);
        check("reset_wr_data", {8'b0, o_wr_data}, 32'd0);
        check("reset_cur", {16'b0, o_cur_value}, 32'h8000);
        check("reset_settled", {31'b0, o_settled}, 32'd0);
        check("reset_tick_miss", {31'b0, o_tick_miss}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            i_step    = vecs[i].step;
            i_pd_mode = vecs[i].pd;
            if (vecs[i].do_set)
                set_target(vecs[i].set_val);
            tick_and_watch(cnt, data);
            check($sformatf("vec%0d_wr_count", i), cnt, vecs[i].exp_cnt);
            if (vecs[i].exp_cnt > 0)
                check($sformatf("vec%0d_wr_data", i), {8'b0, data}, {8'b0, vecs[i].exp_data});
            check($sformatf("vec%0d_cur", i), {16'b0, o_cur_value}, {16'b0, vecs[i].exp_cur});
            if (i == 0)
                check("post_reset_settled", {31'b0, o_settled}, 32'd1);
        end

        // Set and tick on the same edge: the tick still sees the old target.
        @(posedge clk); #1;
        i_set_valid = 1'b1; i_set_value = 16'h1234; i_tick = 1'b1; i_step = 16'h0;
        @(posedge clk); #1;
        i_set_valid = 1'b0; i_tick = 1'b0;
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (o_wr === 1'b1) cnt++;
        end
        check("same_edge_no_wr", cnt, 0);
        check("same_edge_unsettled", {31'b0, o_settled}, 32'd0);
        tick_and_watch(cnt, data);
        check("same_edge_next_wr_count", cnt, 1);
        check("same_edge_next_wr_data", {8'b0, data}, 32'h001234);

        // Driver busy for 52 clocks: ticks during the hold are dropped and flagged.
        set_target(16'h2000);
        @(posedge clk); #1;
        i_tick = 1'b1; i_dac_busy = 1'b1;
        @(posedge clk); #1;
        i_tick = 1'b0;
        cnt = 0;
        for (int c = 0; c < 52; c++) begin
            @(negedge clk);
            if (o_wr === 1'b1) cnt++;
            @(posedge clk); #1;
            i_tick = (c % 10 == 5);
        end
        i_tick = 1'b0; i_dac_busy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (o_wr === 1'b1) cnt++;
        end
        check("busy_hold_wr_count", cnt, 1);
        check("busy_hold_cur", {16'b0, o_cur_value}, 32'h2000);
        check("busy_hold_tick_miss", {31'b0, o_tick_miss}, 32'd1);
        check("busy_hold_settled", {31'b0, o_settled}, 32'd1);
        @(posedge clk); #1;
        i_clr_miss = 1'b1;
        @(posedge clk); #1;
        i_clr_miss = 1'b0;
        @(negedge clk);
        check("clr_miss", {31'b0, o_tick_miss}, 32'd0);

        // Reset while parked in WAIT.
        set_target(16'h4000);
        @(posedge clk); #1;
        i_tick = 1'b1; i_dac_busy = 1'b1;
        @(posedge clk); #1;
        i_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; i_dac_busy = 1'b0;
        @(negedge clk);
        check("midwait_rst_cur", {16'b0, o_cur_value}, 32'h8000);
        check("midwait_rst_wr_data", {8'b0, o_wr_data}, 32'd0);
        check("midwait_rst_settled", {31'b0, o_settled}, 32'd0);
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (o_wr === 1'b1) cnt++;
            @(negedge clk);
        end
        check("midwait_rst_no_wr", cnt, 0);
        tick_and_watch(cnt, data);
        check("midwait_rst_tick_wr_count", cnt, 1);
        check("midwait_rst_tick_wr_data", {8'b0, data}, 32'h008000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Minimum spacing between write pulses is three clocks.
    int since_wr = 100;
    always @(negedge clk) begin
        if (o_wr === 1'b1) begin
            if (since_wr < 3) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wr_spacing: got %0d clocks expected at least 3", since_wr);
            end
            since_wr = 0;
        end else if (since_wr < 100) begin
            since_wr++;
        end
    end

endmodule

// File: doc/dac_slew_ctrl.md
DAC_SLEW_CTRL -- requirements
Module: dac_slew_ctrl

Interface
REQ-001 Parameter INIT_VALUE, default 16'h8000: DAC code used after reset, mid-scale.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_set_valid  input  1  new target strobe; always accepted, no ready.
REQ-005 i_set_value  input  16  target DAC code, unsigned.
REQ-006 i_step  input  16  max code change per update; 0 = unlimited (jump).
REQ-007 i_pd_mode  input  2  DAC power-down mode; 00 = normal operation.
REQ-008 i_tick  input  1  update-rate strobe, one clk wide.
REQ-009 i_dac_busy  input  1  busy status from the downstream SPI DAC driver.
REQ-010 o_wr  output  1  write strobe to the DAC driver, one clk wide.
REQ-011 o_wr_data  output  24  DAC word: {6'b0, pd[1:0], code[15:0]}.
REQ-012 o_cur_value  output  16  code most recently issued (cur).
REQ-013 o_settled  output  1  high when cur == tgt, no pending write and FSM in IDLE.
REQ-014 o_tick_miss  output  1  sticky flag: tick arrived while FSM not in IDLE.
REQ-015 i_clr_miss  input  1  clears o_tick_miss; a simultaneous miss event wins.

Function
REQ-016 Registers: tgt[15:0], cur[15:0], pd_last[1:0], force (1 bit), state.
REQ-017 i_set_valid loads tgt <= i_set_value on that edge in any state; later loads overwrite earlier ones.
REQ-018 FSM states: IDLE, WRITE, WAIT.
REQ-019 IDLE, i_tick = 1, and (cur != tgt or i_pd_mode != pd_last or force): compute next, go to WRITE.
REQ-020 IDLE, i_tick = 1, none of the conditions true: stay in IDLE, no write.
REQ-021 Next-code calculation:
- d = |tgt - cur|, 17-bit unsigned compare, no wrap-around.
- If i_step == 0 or d <= i_step: next = tgt.
- Otherwise: next = cur + i_step when tgt > cur, or cur - i_step when tgt < cur.
- Result always lies within [0, 65535].
REQ-022 On the IDLE->WRITE edge:
- cur <= next.
- pd_last <= i_pd_mode.
- force <= 0.
- o_wr_data <= {6'b0, i_pd_mode, next}.
REQ-023 WRITE lasts exactly one clk: o_wr = 1, then go to WAIT.
REQ-024 WAIT: ignore i_dac_busy in the first WAIT cycle (driver busy is registered).
REQ-025 WAIT, from the second WAIT cycle: return to IDLE when i_dac_busy = 0.
REQ-026 Minimum spacing between consecutive o_wr pulses: 3 clk.
REQ-027 i_tick while state != IDLE: the tick is dropped and o_tick_miss <= 1.
REQ-028 o_wr_data holds its value between writes and changes only on the IDLE->WRITE edge.
REQ-029 o_wr is never asserted in IDLE or WAIT.
REQ-030 i_set_valid and i_tick on the same edge in IDLE: the tick uses the old tgt; the new tgt applies from the next tick.

Reset
REQ-031 Reset values:
- state = IDLE.
- tgt = cur = INIT_VALUE.
- pd_last = 00.
- force = 1.
- o_wr = 0.
- o_wr_data = 0.
- o_tick_miss = 0.
- o_settled = 0.
REQ-032 Because force = 1 after reset, the first tick after reset issues {6'b0, i_pd_mode, INIT_VALUE}.
REQ-033 rst asserted mid-operation (WRITE or WAIT): return to IDLE and restore all REQ-031 values on that edge, with no o_wr pulse after it.

Verification
REQ-034 Post-reset: rst, then one tick with pd = 00 -> single o_wr, data 24'h008000; o_settled = 1 once busy drops.
REQ-035 Slew-limited ramp: set 16'h8100, step 16'h0040 -> four writes: 8040, 8080, 80C0, 8100; then no write on later ticks.
REQ-036 Boundary cases:
- tgt 16'h0000 from cur 16'h0010, step 16'h0020 -> single write 0000, no underflow.
- tgt FFFF, step 0 -> immediate jump to FFFF.
REQ-037 Power-down only: tgt == cur, pd set to 01 -> write 24'h01xxxx carrying the unchanged code; then idle.
REQ-038 Busy hold: model the driver busy for 52 clk; ticks during that time -> no o_wr and o_tick_miss = 1; i_clr_miss clears it.
REQ-039 Reset mid-WAIT: rst -> o_cur_value = 8000 on the next cycle; no o_wr until the next tick.
